// File: rtl/dac_serial_tx.sv
// Serial transmitter for a 12-bit DAC: latches a sample on inicio_tx and shifts
// the 16-bit frame {CTRL, dato_tx} MSB-first on CS/sclk/din, sclk derived from clk.
module dac_serial_tx #(
  parameter int         CLK_DIV = 4,
  parameter logic [3:0] CTRL    = 4'b0011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inicio_tx,
  input  logic [11:0] dato_tx,
  output logic        CS,
  output logic        sclk,
  output logic        din,
  output logic        ocupado,
  output logic        tx_listo
);

  generate
    if (CLK_DIV < 2) begin : g_bad_div
      $error("dac_serial_tx: CLK_DIV must be >= 2");
    end
  endgenerate

  localparam int            DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] div_reg, div_next;
  logic [4:0]    half_reg, half_next;
  logic [15:0]   shift_reg, shift_next;
  logic          cs_reg, cs_next;
  logic          sclk_reg, sclk_next;
  logic          din_reg, din_next;
  logic          ocup_reg, ocup_next;
  logic          listo_reg, listo_next;
  logic          wrap;

  assign wrap = (div_reg == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      half_reg  <= '0;
      shift_reg <= '0;
      cs_reg    <= 1'b1;
      sclk_reg  <= 1'b0;
      din_reg   <= 1'b0;
      ocup_reg  <= 1'b0;
      listo_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      half_reg  <= half_next;
      shift_reg <= shift_next;
      cs_reg    <= cs_next;
      sclk_reg  <= sclk_next;
      din_reg   <= din_next;
      ocup_reg  <= ocup_next;
      listo_reg <= listo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    div_next   = wrap ? '0 : div_reg + DW'(1);
    half_next  = half_reg;
    shift_next = shift_reg;
    cs_next    = cs_reg;
    sclk_next  = sclk_reg;
    din_next   = din_reg;
    ocup_next  = ocup_reg;
    listo_next = 1'b0;
    case (state_reg)
      IDLE: begin
        div_next  = '0;
        half_next = '0;
        if (inicio_tx) begin
          state_next = SETUP;
          shift_next = {CTRL, dato_tx};
          cs_next    = 1'b0;
          ocup_next  = 1'b1;
          din_next   = CTRL[3];
          sclk_next  = 1'b0;
        end
      end
      SETUP: begin
        if (wrap) begin
          state_next = SHIFT;
          sclk_next  = 1'b1;
          half_next  = '0;
        end
      end
      SHIFT: begin
        // half_reg 31 is the low half of the 16th period; din keeps frame[0] from then on
        if (wrap) begin
          if (half_reg == 5'd31) begin
            state_next = HOLD;
          end else begin
            half_next = half_reg + 5'd1;
            sclk_next = ~sclk_reg;
            if (sclk_reg && (half_reg < 5'd30)) begin
              shift_next = {shift_reg[14:0], 1'b0};
              din_next   = shift_reg[14];
            end
          end
        end
      end
      HOLD: begin
        if (wrap) begin
          state_next = GAP;
          cs_next    = 1'b1;
          din_next   = 1'b0;
        end
      end
      GAP: begin
        if (wrap) begin
          state_next = IDLE;
          ocup_next  = 1'b0;
          listo_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign CS       = cs_reg;
  assign sclk     = sclk_reg;
  assign din      = din_reg;
  assign ocupado  = ocup_reg;
  assign tx_listo = listo_reg;

endmodule
